// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//
// Purpose : Shared constants and helpers for the multi-port register file.
//           Holds the hard-wired zero register's address and value, the
//           default data width, and a helper that gives the bit offset of one
//           port's field inside a packed multi-port bus.
//
// Contents:
//   DEFAULT_XLEN   default data width of the register file
//   ZERO_REG_ADDR  architectural index of the register that always reads 0
//   ZERO_REG_DATA  value returned for the zero register
//   port_lsb()     bit offset of port 'port' in a bus of 'width'-bit fields
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int ZERO_REG_ADDR = 0;
    localparam int ZERO_REG_DATA = 0;

    // Ports are packed little-end first: port p occupies [p*width +: width].
    // Every per-port slice in the design goes through this function so the
    // packing order is defined in exactly one place.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Purpose : Per-register pending-write tracker. Decode marks a destination
//           register as busy when it issues an instruction; the busy bit is
//           cleared when the result is written back. Lookup ports report the
//           busy bit of an arbitrary register so the read side can flag RAW
//           hazards.
//
// Update priority within one clock edge (lowest to highest):
//   1. clear busy[wr_addr[j]] for every active write port
//   2. set busy[issue_rd] (a new producer supersedes a retiring one)
//   3. flush clears every bit and overrides the set
//   busy[0] is never set.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en[NWR]        writeback valid per write port
//   wr_addr[NWR*AW]   writeback register per write port
//   issue_en          mark issue_rd as pending
//   issue_rd[AW]      register to mark
//   flush             clear every busy bit this edge
//   lookup_addr       NRD packed register indices to look up
//   lookup_busy[NRD]  busy bit of each looked-up register (registered state)
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NWR  = 1,
    parameter int NRD  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NWR-1:0]                wr_en,
    input  logic [NWR*$clog2(NREG)-1:0]   wr_addr,
    input  logic                          issue_en,
    input  logic [$clog2(NREG)-1:0]       issue_rd,
    input  logic                          flush,
    input  logic [NRD*$clog2(NREG)-1:0]   lookup_addr,
    output logic [NRD-1:0]                lookup_busy
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;

        // Retiring producers release their destination.
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[port_lsb(j, AW) +: AW]] = 1'b0;
            end
        end

        // Applied after the clears so that an issue to a register that is
        // being written back in the same cycle leaves it pending: the value
        // landing now belongs to the older producer.
        if (issue_en && (issue_rd != AW'(ZERO_REG_ADDR))) begin
            busy_d[issue_rd] = 1'b1;
        end

        // Flush discards every in-flight producer, including one issued now.
        if (flush) begin
            busy_d = '0;
        end

        busy_d[ZERO_REG_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_lookup
            assign lookup_busy[gi] = busy_q[lookup_addr[port_lsb(gi, AW) +: AW]];
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Purpose : Parametrised multi-port integer register file with registered read
//           addresses, optional same-cycle write-to-read forwarding and a
//           per-register pending-write scoreboard for RAW hazard detection.
//           Register 0 is hard-wired to zero.
//
// Timing  : Read addresses are captured on a rising edge when rd_en is high
//           and held otherwise. Read data and busy flags are combinational
//           from the captured address, so they track later writes to a held
//           address rather than snapshotting it.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_en               capture rd_addr this edge (low = stall, hold)
//   rd_addr[NRD*AW]     packed read addresses, port i at [i*AW +: AW]
//   rd_data[NRD*XLEN]   packed read data
//   rd_busy[NRD]        captured register still has a write pending
//   wr_en[NWR]          writeback enable per write port
//   wr_addr[NWR*AW]     packed write addresses
//   wr_data[NWR*XLEN]   packed write data
//   issue_en, issue_rd  mark issue_rd as pending-write
//   flush               clear all pending-write bits (data untouched)
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_en,
    input  logic [NRD*$clog2(NREG)-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0]           rd_data,
    output logic [NRD-1:0]                rd_busy,
    input  logic [NWR-1:0]                wr_en,
    input  logic [NWR*$clog2(NREG)-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0]           wr_data,
    input  logic                          issue_en,
    input  logic [$clog2(NREG)-1:0]       issue_rd,
    input  logic                          flush
);

    localparam int AW = $clog2(NREG);

    // -------------------------------------------------------------------------
    // Architectural storage
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] x_q [NREG];
    logic [XLEN-1:0] x_d [NREG];

    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            x_d[k] = x_q[k];
        end

        // Ascending port order: when several ports hit the same register the
        // highest-numbered port is applied last and therefore wins.
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[port_lsb(j, AW) +: AW] != AW'(ZERO_REG_ADDR))) begin
                x_d[wr_addr[port_lsb(j, AW) +: AW]] = wr_data[port_lsb(j, XLEN) +: XLEN];
            end
        end

        x_d[ZERO_REG_ADDR] = XLEN'(ZERO_REG_DATA);
    end

    // Reset must clear every register, so the storage is built from flops
    // rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                x_q[k] <= XLEN'(ZERO_REG_DATA);
            end
        end else begin
            for (int k = 0; k < NREG; k++) begin
                x_q[k] <= x_d[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read address capture
    // -------------------------------------------------------------------------
    logic [AW-1:0]     r_addr_q [NRD];
    logic [AW-1:0]     r_addr_d [NRD];
    logic [NRD*AW-1:0] r_addr_flat;

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_raddr
            assign r_addr_d[gi] = rd_en ? rd_addr[port_lsb(gi, AW) +: AW] : r_addr_q[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_addr_q[gi] <= AW'(ZERO_REG_ADDR);
                end else begin
                    r_addr_q[gi] <= r_addr_d[gi];
                end
            end

            assign r_addr_flat[port_lsb(gi, AW) +: AW] = r_addr_q[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pending-write scoreboard
    // -------------------------------------------------------------------------
    logic [NRD-1:0] sb_busy;

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .NRD  (NRD)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .lookup_addr (r_addr_flat),
        .lookup_busy (sb_busy)
    );

    // -------------------------------------------------------------------------
    // Read data mux with optional forwarding
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic            fwd_hit;
            logic [XLEN-1:0] fwd_data;
            logic            is_zero;

            assign is_zero = (r_addr_q[gi] == AW'(ZERO_REG_ADDR));

            // Highest matching write port supplies the forwarded value, the
            // same port that wins the storage update at the coming edge.
            always_comb begin
                fwd_hit  = 1'b0;
                fwd_data = XLEN'(ZERO_REG_DATA);
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && (wr_addr[port_lsb(j, AW) +: AW] == r_addr_q[gi])) begin
                            fwd_hit  = 1'b1;
                            fwd_data = wr_data[port_lsb(j, XLEN) +: XLEN];
                        end
                    end
                end
            end

            // The zero register never forwards: a write to x0 is discarded,
            // so forwarding it would expose a value that never exists.
            assign rd_data[port_lsb(gi, XLEN) +: XLEN] =
                is_zero ? XLEN'(ZERO_REG_DATA) :
                fwd_hit ? fwd_data             :
                          x_q[r_addr_q[gi]];

            // A forwarded value is already the producer's result, so the
            // consumer need not wait for the clearing edge.
            assign rd_busy[gi] = sb_busy[gi] & ~fwd_hit;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//
// Two instances share one stimulus stream: one with forwarding (BYPASS=1) and
// one without (BYPASS=0), both with two write ports. A directed table walks
// through reads, write priority, x0, forwarding and the scoreboard; a hand
// sequence covers asynchronous reset; a randomized phase compares both
// instances against an array-based model of the architectural state.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;
    localparam int NRND = 200;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data_bp, rd_data_nb;
    logic [NRD-1:0]       rd_busy_bp, rd_busy_nb;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 issue_en;
    logic [AW-1:0]        issue_rd;
    logic                 flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_bp (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_bp), .rd_busy(rd_busy_bp),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush)
    );

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ table
    typedef struct {
        logic        rd_en;
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ird;
        logic        fl;
        logic [31:0] e_d0, e_d1;   // BYPASS=1 read data
        logic [1:0]  e_b;          // BYPASS=1 busy flags
        logic [31:0] e_nd0;        // BYPASS=0 port 0 data
        logic        e_nb0;        // BYPASS=0 port 0 busy
    } vec_t;

    function automatic vec_t mk(
        input logic rden, input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic ie, input logic [4:0] ird, input logic fl,
        input logic [31:0] e_d0, input logic [31:0] e_d1, input logic [1:0] e_b,
        input logic [31:0] e_nd0, input logic e_nb0);
        vec_t v;
        v.rd_en = rden; v.ra0 = ra0; v.ra1 = ra1;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ie = ie; v.ird = ird; v.fl = fl;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_b = e_b; v.e_nd0 = e_nd0; v.e_nb0 = e_nb0;
        return v;
    endfunction

    vec_t tbl[20];

    task automatic drive(input vec_t v);
        rd_en    = v.rd_en;
        rd_addr  = {v.ra1, v.ra0};
        wr_en    = v.we;
        wr_addr  = {v.wa1, v.wa0};
        wr_data  = {v.wd1, v.wd0};
        issue_en = v.ie;
        issue_rd = v.ird;
        flush    = v.fl;
    endtask

    task automatic idle();
        rd_en = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    // ------------------------------------------------------------------ model
    logic [31:0] m_x    [NREG];
    bit          m_busy [NREG];
    logic [4:0]  m_ra   [NRD];

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) begin
            m_x[k] = '0;
            m_busy[k] = 1'b0;
        end
        for (int p = 0; p < NRD; p++) m_ra[p] = '0;
    endtask

    // Is there an active write port aimed at register a this cycle?
    function automatic bit m_write_hits(input logic [4:0] a);
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input int p, input bit bp);
        logic [4:0] a = m_ra[p];
        if (a == 0) return 32'h0;
        if (bp) begin
            for (int j = NWR - 1; j >= 0; j--)
                if (wr_en[j] && wr_addr[j*AW +: AW] == a) return wr_data[j*XLEN +: XLEN];
        end
        return m_x[a];
    endfunction

    function automatic bit m_bsy(input int p, input bit bp);
        logic [4:0] a = m_ra[p];
        if (bp && m_write_hits(a)) return 1'b0;
        return m_busy[a];
    endfunction

    // Architectural effect of one clock edge with the current inputs.
    task automatic model_edge();
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                if (wr_addr[j*AW +: AW] != 0) m_x[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                m_busy[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        if (flush) for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
        if (rd_en) for (int p = 0; p < NRD; p++) m_ra[p] = rd_addr[p*AW +: AW];
    endtask

    // ------------------------------------------------------------------ test
    initial begin
        // x3 write/read, 2-port write priority, x0, forwarding, scoreboard, flush
        tbl[0]  = mk(1, 3, 0, 2'b01, 3, 32'h12345678, 0, 0,  0, 0, 0,  32'h0, 0, 2'b00, 32'h0, 0);
        tbl[1]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,             0, 0, 0,  32'h12345678, 0, 2'b00, 32'h12345678, 0);
        tbl[2]  = mk(1, 9, 0, 2'b11, 9, 32'h11, 9, 32'h22,   0, 0, 0,  32'h12345678, 0, 2'b00, 32'h12345678, 0);
        tbl[3]  = mk(0, 0, 0, 2'b11, 0, 32'hFFFF, 0, 32'hFFFF, 0, 0, 0, 32'h22, 0, 2'b00, 32'h22, 0);
        tbl[4]  = mk(1, 7, 0, 2'b00, 0, 0, 0, 0,             0, 0, 0,  32'h22, 0, 2'b00, 32'h22, 0);
        tbl[5]  = mk(0, 0, 0, 2'b01, 7, 32'hA5A5A5A5, 0, 0,  0, 0, 0,  32'hA5A5A5A5, 0, 2'b00, 32'h0, 0);
        tbl[6]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,             0, 0, 0,  32'hA5A5A5A5, 0, 2'b00, 32'hA5A5A5A5, 0);
        tbl[7]  = mk(1, 4, 4, 2'b00, 0, 0, 0, 0,             1, 4, 0,  32'hA5A5A5A5, 0, 2'b00, 32'hA5A5A5A5, 0);
        tbl[8]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,             0, 0, 0,  32'h0, 0, 2'b11, 32'h0, 1);
        tbl[9]  = mk(0, 0, 0, 2'b10, 0, 0, 4, 32'h44,        1, 4, 0,  32'h44, 32'h44, 2'b00, 32'h0, 1);
        tbl[10] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,             0, 0, 0,  32'h44, 32'h44, 2'b11, 32'h44, 1);
        tbl[11] = mk(0, 0, 0, 2'b01, 4, 32'h55, 0, 0,        0, 0, 0,  32'h55, 32'h55, 2'b00, 32'h44, 1);
        tbl[12] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,             0, 0, 0,  32'h55, 32'h55, 2'b00, 32'h55, 0);
        tbl[13] = mk(1, 1, 6, 2'b00, 0, 0, 0, 0,             1, 1, 0,  32'h55, 32'h55, 2'b00, 32'h55, 0);
        tbl[14] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,             1, 2, 0,  32'h0, 0, 2'b01, 32'h0, 1);
        tbl[15] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,             1, 3, 0,  32'h0, 0, 2'b01, 32'h0, 1);
        tbl[16] = mk(1, 3, 6, 2'b00, 0, 0, 0, 0,             1, 6, 1,  32'h0, 0, 2'b01, 32'h0, 1);
        tbl[17] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,             0, 0, 0,  32'h12345678, 0, 2'b00, 32'h12345678, 0);
        tbl[18] = mk(1, 9, 0, 2'b00, 0, 0, 0, 0,             0, 0, 0,  32'h12345678, 0, 2'b00, 32'h12345678, 0);
        tbl[19] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,             0, 0, 0,  32'h22, 0, 2'b00, 32'h22, 0);

        rst = 1'b1;
        idle();
        @(negedge clk);
        #1;
        chk("reset rd_data bp", rd_data_bp[31:0] | rd_data_bp[63:32], 32'h0);
        chk("reset rd_busy bp", {30'd0, rd_busy_bp}, 32'h0);
        chk("reset rd_data nb", rd_data_nb[31:0] | rd_data_nb[63:32], 32'h0);
        chk("reset rd_busy nb", {30'd0, rd_busy_nb}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 20; r++) begin
            @(negedge clk);
            drive(tbl[r]);
            #1;
            $display("row %0d: d0=%h d1=%h busy=%b | nb d0=%h busy0=%b",
                     r, rd_data_bp[31:0], rd_data_bp[63:32], rd_busy_bp,
                     rd_data_nb[31:0], rd_busy_nb[0]);
            chk($sformatf("row%0d bp d0", r), rd_data_bp[31:0],  tbl[r].e_d0);
            chk($sformatf("row%0d bp d1", r), rd_data_bp[63:32], tbl[r].e_d1);
            chk($sformatf("row%0d bp busy", r), {30'd0, rd_busy_bp}, {30'd0, tbl[r].e_b});
            chk($sformatf("row%0d nb d0", r), rd_data_nb[31:0],  tbl[r].e_nd0);
            chk($sformatf("row%0d nb busy0", r), {31'd0, rd_busy_nb[0]}, {31'd0, tbl[r].e_nb0});
        end

        // Asynchronous reset in the middle of a cycle after x5=0xDEAD.
        @(negedge clk);
        idle();
        rd_en = 1'b1; rd_addr = {5'd5, 5'd5};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h0000DEAD};
        issue_en = 1'b1; issue_rd = 5'd5;
        @(negedge clk);
        idle();
        #1;
        $display("pre-reset: d0=%h d1=%h busy=%b", rd_data_bp[31:0], rd_data_bp[63:32], rd_busy_bp);
        chk("pre-reset bp d0", rd_data_bp[31:0], 32'h0000DEAD);
        chk("pre-reset bp busy", {30'd0, rd_busy_bp}, 32'h3);
        chk("pre-reset nb d1", rd_data_nb[63:32], 32'h0000DEAD);
        #2;
        rst = 1'b1;
        #1;
        $display("mid-reset: d0=%h d1=%h busy=%b", rd_data_bp[31:0], rd_data_bp[63:32], rd_busy_bp);
        chk("async reset bp data", rd_data_bp[31:0] | rd_data_bp[63:32], 32'h0);
        chk("async reset bp busy", {30'd0, rd_busy_bp}, 32'h0);
        chk("async reset nb data", rd_data_nb[31:0] | rd_data_nb[63:32], 32'h0);
        chk("async reset nb busy", {30'd0, rd_busy_nb}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_en = 1'b1; rd_addr = {5'd5, 5'd5};
        @(negedge clk);
        idle();
        #1;
        $display("post-reset x5: d0=%h busy=%b", rd_data_bp[31:0], rd_busy_bp);
        chk("post-reset x5 bp", rd_data_bp[31:0], 32'h0);
        chk("post-reset x5 busy", {30'd0, rd_busy_bp}, 32'h0);
        chk("post-reset x5 nb", rd_data_nb[31:0], 32'h0);

        // Randomized phase against the architectural model.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < NRND; c++) begin
            @(negedge clk);
            rd_en = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = 5'($urandom_range(0, 7));
            wr_en = 2'($urandom_range(0, 3));
            for (int j = 0; j < NWR; j++) begin
                wr_addr[j*AW +: AW] = 5'($urandom_range(0, 7));
                wr_data[j*XLEN +: XLEN] = $urandom;
            end
            issue_en = ($urandom_range(0, 1) != 0);
            issue_rd = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
            #1;
            $display("rnd %0d: ra=%0d,%0d we=%b d=%h,%h busy=%b",
                     c, m_ra[0], m_ra[1], wr_en, rd_data_bp[31:0], rd_data_bp[63:32], rd_busy_bp);
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("rnd%0d bp d%0d", c, p), rd_data_bp[p*XLEN +: XLEN], m_read(p, 1'b1));
                chk($sformatf("rnd%0d nb d%0d", c, p), rd_data_nb[p*XLEN +: XLEN], m_read(p, 1'b0));
                chk($sformatf("rnd%0d bp busy%0d", c, p), {31'd0, rd_busy_bp[p]}, {31'd0, m_bsy(p, 1'b1)});
                chk($sformatf("rnd%0d nb busy%0d", c, p), {31'd0, rd_busy_nb[p]}, {31'd0, m_bsy(p, 1'b0)});
            end
            @(posedge clk);
            model_edge();
        end

        @(negedge clk);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
